// File: rtl/fu_pkg.sv
// fu_pkg: opcode constants, controller state type and immediate sign extension
package fu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  typedef enum logic [1:0] {IDLE, READ_OPS, EXEC, WRITE} fu_state_t;
  // 64-bit result so callers can cast down to any datapath width up to 64
  function automatic logic [63:0] sign_ext16(input logic [15:0] x);
    return {{48{x[15]}}, x};
  endfunction
endpackage

// File: rtl/fu_decode.sv
// fu_decode: instruction word to operand needs, destination register and write-back kind
module fu_decode import fu_pkg::*; #(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       ir,
  output logic              needs_rs,
  output logic              needs_rt,
  output logic [REG_AW-1:0] rd,
  output logic              we_reg,
  output logic              is_store
);
  logic is_rr, is_imm, is_sw, unused_shamt;
  assign is_rr        = ir[31:26] == OP_RTYPE && (ir[5:0] == FN_ADD || ir[5:0] == FN_SUB);
  assign is_imm       = ir[31:26] == OP_ADDI || ir[31:26] == OP_LW;
  assign is_sw        = ir[31:26] == OP_SW;
  assign needs_rs     = is_rr || is_imm || is_sw;
  assign needs_rt     = is_rr || is_sw;
  assign we_reg       = is_rr || is_imm;
  assign is_store     = is_sw;
  assign rd           = is_rr ? REG_AW'(ir[15:11]) : is_imm ? REG_AW'(ir[20:16]) : '0;
  assign unused_shamt = ^ir[10:6];
endmodule

// File: rtl/fu_control.sv
// fu_control: issue -> operand read -> fixed-latency ALU drive -> held write-back request.
// Define FU_STALL_CNT_EN to add saturating stall_rd_cnt / stall_wb_cnt outputs.
module fu_control import fu_pkg::*; #(
  parameter int EXEC_LAT = 1,
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [31:0]       issue_ir,
  input  logic              rj_ready,
  input  logic              rk_ready,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              read_done,
  output logic [31:0]       alu_ir,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  output logic [DATA_W-1:0] alu_imm,
  input  logic [DATA_W-1:0] alu_saida,
  input  logic [9:0]        alu_mem_dest,
  output logic              wb_req,
  input  logic              wb_grant,
  output logic [DATA_W-1:0] wb_data,
  output logic [9:0]        wb_mem_dest,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_we_reg,
  output logic              wb_is_store,
  output logic              busy
`ifdef FU_STALL_CNT_EN
  ,
  output logic [31:0]       stall_rd_cnt,
  output logic [31:0]       stall_wb_cnt
`endif
);
  fu_state_t state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [9:0] mdest_q, mdest_d;
  logic [3:0] cnt_q, cnt_d;
  logic needs_rs, needs_rt, ops_ok;
  fu_decode #(.REG_AW(REG_AW)) u_dec (
    .ir(ir_q), .needs_rs(needs_rs), .needs_rt(needs_rt),
    .rd(wb_rd), .we_reg(wb_we_reg), .is_store(wb_is_store)
  );
  assign ops_ok = (rj_ready || !needs_rs) && (rk_ready || !needs_rt);
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    mdest_d = mdest_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (issue_valid) begin
        ir_d    = issue_ir;
        state_d = READ_OPS;
      end
      READ_OPS: if (ops_ok) begin
        op1_d   = rs_data;
        op2_d   = needs_rt ? rt_data : '0;
        cnt_d   = 4'(EXEC_LAT - 1);
        state_d = EXEC;
      end
      EXEC: if (cnt_q == 4'd0) begin
        res_d   = alu_saida;
        mdest_d = alu_mem_dest;
        state_d = WRITE;
      end else cnt_d = cnt_q - 4'd1;
      default: if (wb_grant) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      mdest_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      mdest_q <= mdest_d;
      cnt_q   <= cnt_d;
    end
  end
  assign issue_ready = state_q == IDLE;
  assign busy        = !issue_ready;
  assign read_done   = state_q == READ_OPS && ops_ok;
  assign wb_req      = state_q == WRITE;
  assign rs_addr     = REG_AW'(ir_q[25:21]);
  assign rt_addr     = REG_AW'(ir_q[20:16]);
  assign alu_ir      = busy ? ir_q : '0;
  assign alu_in_1    = busy ? op1_q : '0;
  assign alu_in_2    = busy ? op2_q : '0;
  assign alu_imm     = busy ? DATA_W'(sign_ext16(ir_q[15:0])) : '0;
  assign wb_data     = res_q;
  assign wb_mem_dest = mdest_q;
`ifdef FU_STALL_CNT_EN
  logic [31:0] srd_q, srd_d, swb_q, swb_d;
  always_comb begin
    srd_d = (state_q == READ_OPS && !ops_ok && srd_q != '1) ? srd_q + 32'd1 : srd_q;
    swb_d = (state_q == WRITE && !wb_grant && swb_q != '1) ? swb_q + 32'd1 : swb_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      srd_q <= '0;
      swb_q <= '0;
    end else begin
      srd_q <= srd_d;
      swb_q <= swb_d;
    end
  end
  assign stall_rd_cnt = srd_q;
  assign stall_wb_cnt = swb_q;
`endif
endmodule

// File: tb/tb_fu_control.sv
// tb_fu_control: directed + randomized instruction flow against a behavioural model
module tb_fu_control;
  localparam int LAT = 3;
  logic clock = 0, reset_n = 0, issue_valid = 0, rj_ready = 0, rk_ready = 0, wb_grant = 0;
  logic [31:0] issue_ir = 0, rs_data, rt_data, alu_ir, alu_in_1, alu_in_2, alu_imm, alu_saida, wb_data;
  logic [9:0] alu_mem_dest, wb_mem_dest;
  logic [4:0] rs_addr, rt_addr, wb_rd;
  logic issue_ready, read_done, wb_req, wb_we_reg, wb_is_store, busy;
`ifdef FU_STALL_CNT_EN
  logic [31:0] stall_rd_cnt, stall_wb_cnt;
`endif
  logic [31:0] rf [32];
  int nvec = 0, nerr = 0;
  always #5 clock = ~clock;
  fu_control #(.EXEC_LAT(LAT), .DATA_W(32), .REG_AW(5)) dut (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_ir(issue_ir), .rj_ready(rj_ready), .rk_ready(rk_ready), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data), .read_done(read_done),
    .alu_ir(alu_ir), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_imm(alu_imm),
    .alu_saida(alu_saida), .alu_mem_dest(alu_mem_dest), .wb_req(wb_req), .wb_grant(wb_grant),
    .wb_data(wb_data), .wb_mem_dest(wb_mem_dest), .wb_rd(wb_rd), .wb_we_reg(wb_we_reg),
    .wb_is_store(wb_is_store), .busy(busy)
`ifdef FU_STALL_CNT_EN
    , .stall_rd_cnt(stall_rd_cnt), .stall_wb_cnt(stall_wb_cnt)
`endif
  );
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];
  // stub ALU: {mem_dest, result}
  function automatic logic [41:0] alu_fn(input logic [31:0] ir, a, b, imm);
    logic [31:0] ea;
    ea = a + imm;
    case (ir[31:26])
      6'h00:   return ir[5:0] == 6'h20 ? {ir[9:0], a + b} : ir[5:0] == 6'h22 ? {ir[9:0], a - b} : {ir[9:0], a ^ imm};
      6'h08:   return {10'd0, ea};
      6'h23:   return {ea[9:0], ea};
      6'h2b:   return {ea[9:0], b};
      default: return {ir[9:0], a ^ imm};
    endcase
  endfunction
  always_comb {alu_mem_dest, alu_saida} = alu_fn(alu_ir, alu_in_1, alu_in_2, alu_imm);
  // 0 = nop, 1 = add/sub, 2 = addi/lw, 3 = sw
  function automatic int kind(input logic [31:0] ir);
    if (ir[31:26] == 6'h00 && (ir[5:0] == 6'h20 || ir[5:0] == 6'h22)) return 1;
    if (ir[31:26] == 6'h08 || ir[31:26] == 6'h23) return 2;
    if (ir[31:26] == 6'h2b) return 3;
    return 0;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [31:0] ir, input int srj, input int srk, input int g, input bit early_grant);
    int k, wait_n;
    logic [31:0] a, b, imm, exp_data;
    logic [9:0] exp_md;
    logic [4:0] exp_rd;
`ifdef FU_STALL_CNT_EN
    logic [31:0] rd0, wb0;
    rd0 = stall_rd_cnt;
    wb0 = stall_wb_cnt;
`endif
    k = kind(ir);
    wait_n = (k == 0) ? 0 : ((k == 2) ? srj : (srj > srk ? srj : srk));
    a = rf[ir[25:21]];
    b = (k == 1 || k == 3) ? rf[ir[20:16]] : 32'd0;
    imm = {{16{ir[15]}}, ir[15:0]};
    {exp_md, exp_data} = alu_fn(ir, a, b, imm);
    exp_rd = (k == 1) ? ir[15:11] : (k == 2) ? ir[20:16] : 5'd0;
    chk("issue_ready_idle", issue_ready, 1);
    issue_valid = 1;
    issue_ir = ir;
    rj_ready = srj == 0;
    rk_ready = srk == 0;
    wb_grant = early_grant;
    @(negedge clock);
    for (int c = 0; c <= wait_n; c++) begin
      rj_ready = c >= srj;
      rk_ready = c >= srk;
      issue_valid = 1'($urandom);
      issue_ir = $urandom;
      wb_grant = early_grant | 1'($urandom);
      #1;
      chk("read_done", read_done, c == wait_n);
      chk("rs_addr", rs_addr, ir[25:21]);
      chk("issue_ready_rd", issue_ready, 0);
      @(negedge clock);
    end
    for (int j = 0; j < LAT; j++) begin
      rj_ready = 1'($urandom);
      rk_ready = 1'($urandom);
      wb_grant = early_grant | 1'($urandom);
      chk("alu_ops", {alu_in_1, alu_in_2}, {a, b});
      chk("alu_ir_imm", {alu_ir, alu_imm}, {ir, imm});
      chk("exec_no_wb", {wb_req, read_done, busy}, 3'b001);
      @(negedge clock);
    end
`ifdef FU_STALL_CNT_EN
    chk("stall_rd_cnt", stall_rd_cnt - rd0, wait_n);
`endif
    for (int j = 0; j <= g; j++) begin
      wb_grant = j == g;
      issue_valid = 1;
      #1;
      chk("wb_req", {wb_req, issue_ready}, 2'b10);
      chk("wb_data", {wb_mem_dest, wb_data}, {exp_md, exp_data});
      chk("wb_ctl", {wb_rd, wb_we_reg, wb_is_store}, {exp_rd, k == 1 || k == 2, k == 3});
      @(negedge clock);
    end
    issue_valid = 0;
    wb_grant = 0;
    chk("back_idle", {busy, wb_req, issue_ready}, 3'b001);
`ifdef FU_STALL_CNT_EN
    chk("stall_wb_cnt", stall_wb_cnt - wb0, g);
`endif
  endtask
  initial begin
    logic [31:0] ir;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    repeat (2) @(negedge clock);
    chk("rst_ctl", {issue_ready, busy, wb_req, read_done}, 4'b1000);
    chk("rst_alu", {alu_ir, alu_in_1, alu_in_2, alu_imm}, 128'd0);
    chk("rst_wb", {wb_data, wb_mem_dest, wb_rd, wb_we_reg, wb_is_store}, 49'd0);
    reset_n = 1;
    @(negedge clock);
    rf[1] = 5; rf[2] = 7;
    run(32'h00221820, 0, 0, 0, 1);
    run(32'h2022FFFF, 4, 7, 0, 0);
    rf[1] = 32'h10; rf[2] = 32'h55;
    run(32'hAC220004, 0, 0, 1, 0);
    run(32'h00430822, 2, 3, 5, 0);
    run(32'hFC000000, 3, 3, 0, 0);
    rf[3] = 32'hFFFF_FFFE;
    run(32'h8C64FFF0, 1, 0, 2, 0);
    issue_valid = 1; issue_ir = 32'h00221820; rj_ready = 1; rk_ready = 1;
    @(negedge clock);
    issue_valid = 0;
    @(negedge clock);
    chk("pre_reset_exec", {busy, wb_req}, 2'b10);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    chk("mid_rst_ctl", {issue_ready, busy, wb_req, read_done}, 4'b1000);
    chk("mid_rst_alu", {alu_ir, alu_in_1, alu_in_2, alu_imm}, 128'd0);
    chk("mid_rst_wb", {wb_data, wb_mem_dest, wb_rd, wb_we_reg, wb_is_store}, 49'd0);
    repeat (LAT + 2) begin
      @(negedge clock);
      chk("mid_rst_quiet", {wb_req, busy}, 2'b00);
    end
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      ir = $urandom;
      case ($urandom_range(0, 6))
        0: begin ir[31:26] = 6'h00; ir[5:0] = 6'h20; end
        1: begin ir[31:26] = 6'h00; ir[5:0] = 6'h22; end
        2: ir[31:26] = 6'h08;
        3: ir[31:26] = 6'h23;
        4: ir[31:26] = 6'h2b;
        5: begin ir[31:26] = 6'h00; ir[5:0] = 6'h25; end
        default: ir[31:26] = 6'h0D;
      endcase
      run(ir, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge clock);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
